// File: rtl/uart_bus_arbiter_pkg.sv
// Shared types and constants for the UART bus arbiter.
package uart_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_SETUP,
    ARB_STROBE,
    ARB_CAPTURE,
    ARB_DONE
  } ArbState;

  localparam logic BUS_ACTIVE   = 1'b0;
  localparam logic BUS_INACTIVE = 1'b1;

  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 3;

  // One requester's access as latched at the grant point.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } arb_cmd_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 2) ? 2 : 1;
  endfunction

endpackage

// File: rtl/uart_arb_picker.sv
// Combinational winner selection: round-robin when UART_ARB_RR_EN is defined,
// otherwise fixed priority with the lowest index winning.
module uart_arb_picker
  import uart_bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
`ifdef UART_ARB_RR_EN
  input  logic [IDX_W-1:0]   i_ptr,
`endif
  output logic [NUM_REQ-1:0] o_onehot,
  output logic [IDX_W-1:0]   o_idx
);

`ifdef UART_ARB_RR_EN
  logic             w_found;
  logic [IDX_W-1:0] w_slot;

  // Scan starting at the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    w_found  = 1'b0;
    w_slot   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_slot = IDX_W'((32'(i_ptr) + k) % NUM_REQ);
      if (!w_found && i_req[w_slot]) begin
        w_found          = 1'b1;
        o_idx            = w_slot;
        o_onehot[w_slot] = 1'b1;
      end
    end
  end
`else
  // Descending scan so the lowest requesting index is the last to overwrite.
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_req[k]) begin
        o_onehot    = '0;
        o_onehot[k] = 1'b1;
        o_idx       = IDX_W'(k);
      end
    end
  end
`endif

endmodule

// File: rtl/uart_bus_arbiter.sv
// Shares the UART register port between NUM_REQ requesters using fixed-timing
// bus cycles. Define UART_ARB_RR_EN for round-robin; default is fixed priority.
module uart_bus_arbiter
  import uart_bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 2,
  parameter int unsigned STROBE_CYCLES = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ-1:0]         we_i,
  input  logic [ADDR_W*NUM_REQ-1:0]  addr_i,
  input  logic [DATA_W*NUM_REQ-1:0]  wdata_i,
  output logic [NUM_REQ-1:0]         ack_o,
  output logic [DATA_W-1:0]          rdata_o,
  output logic [NUM_REQ-1:0]         grant_o,
  output logic                       bus_cs,
  output logic                       bus_rd,
  output logic                       bus_wr,
  output logic [ADDR_W-1:0]          bus_addr,
  output logic [DATA_W-1:0]          bus_wdata,
  input  logic [DATA_W-1:0]          bus_rdata
);

  localparam int unsigned     IDX_W       = idx_width(NUM_REQ);
  localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYCLES - 1);

  ArbState             r_state;
  ArbState             w_state_next;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_we;
  logic [NUM_REQ-1:0]  w_pick_onehot;
  logic [IDX_W-1:0]    w_pick_idx;
  arb_cmd_t            w_pick_cmd;

  logic                w_cs_d;
  logic                w_rd_d;
  logic                w_wr_d;
  logic                w_we_d;
  logic [ADDR_W-1:0]   w_addr_d;
  logic [DATA_W-1:0]   w_wdata_d;
  logic [DATA_W-1:0]   w_rdata_d;
  logic [NUM_REQ-1:0]  w_grant_d;
  logic [NUM_REQ-1:0]  w_ack_d;

`ifdef UART_ARB_RR_EN
  logic [IDX_W-1:0]    r_ptr;
  logic [IDX_W-1:0]    r_idx;
`endif

  uart_arb_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .i_req    (req_i),
`ifdef UART_ARB_RR_EN
    .i_ptr    (r_ptr),
`endif
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx)
  );

  always_comb begin
    w_pick_cmd.we    = we_i[w_pick_idx];
    w_pick_cmd.addr  = addr_i[ADDR_W*32'(w_pick_idx) +: ADDR_W];
    w_pick_cmd.wdata = wdata_i[DATA_W*32'(w_pick_idx) +: DATA_W];
  end

  // State register, strobe counter and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state   <= ARB_IDLE;
      r_cnt     <= '0;
      r_we      <= 1'b0;
      bus_cs    <= BUS_INACTIVE;
      bus_rd    <= BUS_INACTIVE;
      bus_wr    <= BUS_INACTIVE;
      bus_addr  <= '0;
      bus_wdata <= '0;
      rdata_o   <= '0;
      grant_o   <= '0;
      ack_o     <= '0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= (r_state == ARB_STROBE) ? r_cnt + 1'b1 : '0;
      r_we      <= w_we_d;
      bus_cs    <= w_cs_d;
      bus_rd    <= w_rd_d;
      bus_wr    <= w_wr_d;
      bus_addr  <= w_addr_d;
      bus_wdata <= w_wdata_d;
      rdata_o   <= w_rdata_d;
      grant_o   <= w_grant_d;
      ack_o     <= w_ack_d;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ARB_IDLE:    if (|req_i) w_state_next = ARB_SETUP;
      ARB_SETUP:   w_state_next = ARB_STROBE;
      ARB_STROBE:  if (r_cnt == STROBE_LAST) w_state_next = ARB_CAPTURE;
      ARB_CAPTURE: w_state_next = ARB_DONE;
      ARB_DONE:    w_state_next = ARB_IDLE;
      default:     w_state_next = ARB_IDLE;
    endcase
  end

  // Outputs are computed for the state being entered so they are valid in it.
  always_comb begin
    w_cs_d    = BUS_INACTIVE;
    w_rd_d    = BUS_INACTIVE;
    w_wr_d    = BUS_INACTIVE;
    w_we_d    = r_we;
    w_addr_d  = bus_addr;
    w_wdata_d = bus_wdata;
    w_rdata_d = rdata_o;
    w_grant_d = grant_o;
    w_ack_d   = '0;
    case (w_state_next)
      ARB_SETUP: begin
        w_cs_d    = BUS_ACTIVE;
        w_grant_d = w_pick_onehot;
        w_we_d    = w_pick_cmd.we;
        w_addr_d  = w_pick_cmd.addr;
        w_wdata_d = w_pick_cmd.wdata;
      end
      ARB_STROBE: begin
        w_cs_d = BUS_ACTIVE;
        w_rd_d = r_we ? BUS_INACTIVE : BUS_ACTIVE;
        w_wr_d = r_we ? BUS_ACTIVE : BUS_INACTIVE;
      end
      ARB_CAPTURE: begin
        w_cs_d = BUS_ACTIVE;
        if (!r_we) w_rdata_d = bus_rdata;
      end
      ARB_DONE: begin
        w_ack_d   = grant_o;
        w_grant_d = '0;
      end
      default: ;
    endcase
  end

`ifdef UART_ARB_RR_EN
  // Pointer moves past the winner once its access completes.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_ptr <= '0;
      r_idx <= '0;
    end else begin
      if (r_state == ARB_IDLE && w_state_next == ARB_SETUP) r_idx <= w_pick_idx;
      if (r_state == ARB_DONE) r_ptr <= IDX_W'((32'(r_idx) + 1) % NUM_REQ);
    end
  end
`endif

endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Self-checking bench for uart_bus_arbiter (S=1 and S=3 instances); honours UART_ARB_RR_EN.
module tb_uart_bus_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] req   = '0;
  logic [1:0] req3  = '0;
  logic [1:0] we    = '0;
  logic [3:0] addr  = '0;
  logic [15:0] wdata = '0;

  logic [1:0] ack, grant, ack3, grant3;
  logic [7:0] rdata, rdata3, bwdata, bwdata3, brdata, brdata3;
  logic       cs, rd, wr, cs3, rd3, wr3;
  logic [1:0] baddr, baddr3;

  logic [7:0] uart_mem [4];
  logic [7:0] exp_mem  [4];
  logic [7:0] last_rd, last_rd3;
  int         ptr, ptr3;
  int         errors = 0;
  int         checks = 0;

  always #5 clock = ~clock;

  uart_bus_arbiter #(.NUM_REQ(2), .STROBE_CYCLES(1)) dut (
    .clock(clock), .reset(reset), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .ack_o(ack), .rdata_o(rdata), .grant_o(grant), .bus_cs(cs), .bus_rd(rd), .bus_wr(wr),
    .bus_addr(baddr), .bus_wdata(bwdata), .bus_rdata(brdata));

  uart_bus_arbiter #(.NUM_REQ(2), .STROBE_CYCLES(3)) dut3 (
    .clock(clock), .reset(reset), .req_i(req3), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .ack_o(ack3), .rdata_o(rdata3), .grant_o(grant3), .bus_cs(cs3), .bus_rd(rd3), .bus_wr(wr3),
    .bus_addr(baddr3), .bus_wdata(bwdata3), .bus_rdata(brdata3));

  // Simple UART register file behind the S=1 instance; fixed read value behind S=3.
  assign brdata  = uart_mem[baddr];
  assign brdata3 = 8'h3C;
  always @(posedge clock)
    if (!reset) uart_mem <= '{8'hA7, 8'h11, 8'h22, 8'h33};
    else if (!cs && !wr) uart_mem[baddr] <= bwdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_mem  = '{8'hA7, 8'h11, 8'h22, 8'h33};
    last_rd  = 8'h00;
    last_rd3 = 8'h00;
    ptr      = 0;
    ptr3     = 0;
  endtask

  function automatic int predict(input logic [1:0] r, input int p);
`ifdef UART_ARB_RR_EN
    for (int k = 0; k < 2; k++) if (r[(p + k) % 2]) return (p + k) % 2;
`else
    for (int k = 0; k < 2; k++) if (r[k]) return k;
`endif
    return 0;
  endfunction

  task automatic set_lane(input int l, input logic w, input logic [1:0] a, input logic [7:0] d);
    we[l]          = w;
    addr[l*2 +: 2] = a;
    wdata[l*8 +: 8] = d;
  endtask

  // Called at a negedge in an IDLE cycle with at least one request pending.
  // Returns at the negedge of the following IDLE cycle.
  task automatic access(input bit d3, input bit hold, input bit drop, output int win);
    int s, cs_low, stb_low, oth_low, early;
    logic ewe, o_cs, o_rd, o_wr;
    logic [1:0] eaddr, o_ack, o_grant, o_addr, g1, a2, ackf, gf;
    logic [7:0] ewd, erd, o_wd, o_rdata, wd2, rdf;
    s = d3 ? 3 : 1;
    win = predict(d3 ? req3 : req, d3 ? ptr3 : ptr);
    ewe = we[win];
    eaddr = addr[win*2 +: 2];
    ewd = wdata[win*8 +: 8];
    erd = ewe ? (d3 ? last_rd3 : last_rd) : (d3 ? 8'h3C : exp_mem[eaddr]);
    cs_low = 0; stb_low = 0; oth_low = 0; early = 0;
    g1 = '0; a2 = '0; wd2 = '0; ackf = '0; gf = '0; rdf = '0;
    for (int k = 1; k <= 3 + s; k++) begin
      @(negedge clock);
      o_cs = d3 ? cs3 : cs;   o_rd = d3 ? rd3 : rd;   o_wr = d3 ? wr3 : wr;
      o_ack = d3 ? ack3 : ack; o_grant = d3 ? grant3 : grant;
      o_addr = d3 ? baddr3 : baddr; o_wd = d3 ? bwdata3 : bwdata;
      o_rdata = d3 ? rdata3 : rdata;
      if (k == 1) g1 = o_grant;
      if (k == 2) begin a2 = o_addr; wd2 = o_wd; end
      if (!o_cs) cs_low++;
      if (!(ewe ? o_wr : o_rd)) stb_low++;
      if (!(ewe ? o_rd : o_wr)) oth_low++;
      if (k < 3 + s && o_ack != 2'b00) early++;
      if (k == 3 + s) begin ackf = o_ack; gf = o_grant; rdf = o_rdata; end
      if (drop && k == 1) begin
        if (d3) req3[win] = 1'b0; else req[win] = 1'b0;
      end
    end
    if (!hold) begin
      if (d3) req3[win] = 1'b0; else req[win] = 1'b0;
    end
    check("grant_onehot", 32'(g1), 32'(2'b01 << win));
    check("cs_low_cycles", 32'(cs_low), 32'(2 + s));
    check("strobe_low_cycles", 32'(stb_low), 32'(s));
    check("wrong_strobe_cycles", 32'(oth_low), 32'd0);
    check("bus_addr", 32'(a2), 32'(eaddr));
    if (ewe) check("bus_wdata", 32'(wd2), 32'(ewd));
    check("early_ack", 32'(early), 32'd0);
    check("ack_pulse", 32'(ackf), 32'(2'b01 << win));
    check("grant_cleared", 32'(gf), 32'd0);
    check("rdata_in_ack", 32'(rdf), 32'(erd));
    @(negedge clock);
    check("cs_high_gap", 32'(d3 ? cs3 : cs), 32'd1);
    check("ack_one_cycle", 32'(d3 ? ack3 : ack), 32'd0);
    if (d3) begin
      ptr3 = (win + 1) % 2;
      if (!ewe) last_rd3 = erd;
    end else begin
      ptr = (win + 1) % 2;
      if (ewe) exp_mem[eaddr] = ewd; else last_rd = erd;
    end
  endtask

  initial begin
    int w, busy;
    model_reset();
    repeat (3) @(negedge clock);
    check("rst_cs", 32'(cs), 32'd1);
    check("rst_rd_wr", 32'({rd, wr}), 32'h3);
    check("rst_addr_wdata", 32'({baddr, bwdata}), 32'd0);
    check("rst_ack_grant", 32'({ack, grant}), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_cs3", 32'(cs3), 32'd1);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("idle_no_req", 32'({cs, rd, wr, grant}), 32'h1C);

    // 1: write lane0 addr1 0x55
    set_lane(0, 1'b1, 2'd1, 8'h55);
    req[0] = 1'b1;
    access(1'b0, 1'b0, 1'b0, w);

    // 2: read lane1 addr0, UART returns 0xA7; value held afterwards
    set_lane(1, 1'b0, 2'd0, 8'h00);
    req[1] = 1'b1;
    access(1'b0, 1'b0, 1'b0, w);
    repeat (2) @(negedge clock);
    check("rdata_held", 32'(rdata), 32'hA7);

    // 3: both lanes held for 8 accesses
    set_lane(0, 1'b0, 2'd2, 8'h00);
    set_lane(1, 1'b1, 2'd3, 8'h9E);
    req = 2'b11;
    for (int i = 0; i < 8; i++) begin
      access(1'b0, 1'b1, 1'b0, w);
`ifdef UART_ARB_RR_EN
      check("grant_order", 32'(w), 32'(i % 2));
`else
      check("grant_order", 32'(w), 32'd0);
`endif
    end
    req = 2'b00;
    repeat (2) @(negedge clock);

    // 4: reset during strobe, then the held request is served again
    set_lane(0, 1'b0, 2'd3, 8'h00);
    req[0] = 1'b1;
    repeat (2) @(negedge clock);
    check("t4_in_strobe", 32'(rd), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("t4_strobes_dropped", 32'({cs, rd, wr}), 32'h7);
    check("t4_ack_grant", 32'({ack, grant}), 32'd0);
    check("t4_rdata", 32'(rdata), 32'd0);
    reset = 1'b1;
    model_reset();
    access(1'b0, 1'b0, 1'b0, w);

    // 5: three-cycle strobe instance, write then read
    set_lane(0, 1'b1, 2'd2, 8'hC3);
    req3[0] = 1'b1;
    access(1'b1, 1'b0, 1'b0, w);
    set_lane(0, 1'b0, 2'd1, 8'h00);
    req3[0] = 1'b1;
    access(1'b1, 1'b0, 1'b0, w);

    // 6: request dropped during setup still completes exactly once
    set_lane(0, 1'b1, 2'd0, 8'h5A);
    req[0] = 1'b1;
    access(1'b0, 1'b1, 1'b1, w);
    busy = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      if (!cs || ack != 2'b00) busy++;
    end
    check("t6_no_second_access", 32'(busy), 32'd0);

    // Randomized traffic against the transaction model
    for (int i = 0; i < 40; i++) begin
      for (int l = 0; l < 2; l++) begin
        if (!req[l] && $urandom_range(0, 1) == 1) begin
          set_lane(l, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom));
          req[l] = 1'b1;
        end
      end
      if (req == 2'b00) begin
        set_lane(1, 1'b0, 2'($urandom_range(0, 3)), 8'h00);
        req[1] = 1'b1;
      end
      access(1'b0, 1'b0, 1'($urandom_range(0, 7) == 0), w);
    end
    req = 2'b00;
    repeat (3) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
